// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port: FSM states, funct3 access codes,
// access-size decode and the default bus timeout.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } acc_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Reserved encodings (011, 110, 111) behave as word accesses.
  function automatic acc_size_e access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// Word-addressed request/acknowledge bus between the data-memory port (master) and memory (slave).
interface dmem_port_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: alignment check, store lane enables and data replication,
// and right-justification of load data (no sign/zero extension).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [1:0]  load_off,
  input  logic [31:0] load_raw,
  output logic        aligned,
  output logic [3:0]  sel,
  output logic [31:0] dat_o,
  output logic [31:0] load_data
);

  acc_size_e   size;
  logic [31:0] rep_b;
  logic [31:0] rep_h;

  assign size = access_size(funct3);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign rep_b[gi*8 +: 8] = wdata[7:0];
    assign rep_h[gi*8 +: 8] = wdata[(gi % 2)*8 +: 8];
  end

  always_comb begin
    aligned = 1'b1;
    sel     = 4'b1111;
    dat_o   = wdata;
    case (size)
      SZ_B: begin
        dat_o = rep_b;
        if (we) sel = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        aligned = ~addr_lo[0];
        dat_o   = rep_h;
        if (we) sel = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        aligned = (addr_lo == 2'b00);
      end
    endcase
  end

  assign load_data = load_raw >> {load_off, 3'b000};

endmodule

// File: rtl/dmem_port.sv
// Load/store unit bus port: IDLE -> REQ -> DONE handshake with alignment faults and bus errors.
// Optional REQ timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        read_data,
  output logic               stall,
  output logic               misaligned,
  output logic               bus_fault,
  dmem_port_if.master        bus
);

  dmem_state_e state_reg;
  logic        cyc_reg;
  logic        we_reg;
  logic [31:0] adr_reg;
  logic [3:0]  sel_reg;
  logic [31:0] dat_o_reg;
  logic [1:0]  off_reg;
  logic [31:0] read_data_reg;
  logic        misaligned_reg;
  logic        fault_reg;

  logic        aligned;
  logic [3:0]  sel_next;
  logic [31:0] dat_o_next;
  logic [31:0] load_data;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] timeout_cnt_reg;
`endif

  dmem_lane_align u_lane_align (
    .funct3    (funct3),
    .addr_lo   (addr[1:0]),
    .we        (mem_we),
    .wdata     (wdata),
    .load_off  (off_reg),
    .load_raw  (bus.dat_i),
    .aligned   (aligned),
    .sel       (sel_next),
    .dat_o     (dat_o_next),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cyc_reg        <= 1'b0;
      we_reg         <= 1'b0;
      adr_reg        <= '0;
      sel_reg        <= '0;
      dat_o_reg      <= '0;
      off_reg        <= '0;
      read_data_reg  <= '0;
      misaligned_reg <= 1'b0;
      fault_reg      <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      misaligned_reg <= 1'b0;
      fault_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_req) begin
            if (aligned) begin
              state_reg <= ST_REQ;
              cyc_reg   <= 1'b1;
              we_reg    <= mem_we;
              adr_reg   <= {addr[31:2], 2'b00};
              sel_reg   <= sel_next;
              dat_o_reg <= dat_o_next;
              off_reg   <= addr[1:0];
`ifdef DMEM_TIMEOUT_EN
              timeout_cnt_reg <= '0;
`endif
            end else begin
              state_reg      <= ST_DONE;
              misaligned_reg <= 1'b1;
              read_data_reg  <= '0;
            end
          end
        end
        ST_REQ: begin
          // Error takes priority over a simultaneous acknowledge.
          if (bus.err) begin
            state_reg     <= ST_DONE;
            cyc_reg       <= 1'b0;
            fault_reg     <= 1'b1;
            read_data_reg <= '0;
          end else if (bus.ack) begin
            state_reg <= ST_DONE;
            cyc_reg   <= 1'b0;
            if (!we_reg) read_data_reg <= load_data;
          end else begin
`ifdef DMEM_TIMEOUT_EN
            if (timeout_cnt_reg == TIMEOUT_LAST) begin
              state_reg     <= ST_DONE;
              cyc_reg       <= 1'b0;
              fault_reg     <= 1'b1;
              read_data_reg <= '0;
            end else begin
              timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end
`endif
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall      = mem_req & (state_reg != ST_DONE);
  assign read_data  = read_data_reg;
  assign misaligned = misaligned_reg;
  assign bus_fault  = fault_reg;

  assign bus.cyc   = cyc_reg;
  assign bus.stb   = cyc_reg;
  assign bus.we    = we_reg;
  assign bus.adr   = adr_reg;
  assign bus.sel   = sel_reg;
  assign bus.dat_o = dat_o_reg;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed cases plus randomized accesses against a byte-level model.
module tb_dmem_port;
  import dmem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        stall;
  logic        misaligned;
  logic        bus_fault;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_model = '0;

  dmem_port_if bus_if ();

  dmem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_fault  (bus_fault),
    .bus        (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // resp: 0 = ack, 1 = err, 2 = ack and err together
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input int resp,
                        input logic [31:0] rdat);
    int          sz;
    bit          al;
    int          stall_cycles;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    sz = size_of(f3);
    al = (a % sz) == 0;
    exp_sel = 4'hF;
    if (we) exp_sel = 4'(((1 << sz) - 1) << (a % 4));
    for (int i = 0; i < 4; i++) exp_dat[8*i +: 8] = wd[8*(i % sz) +: 8];

    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    #1;
    stall_cycles = stall ? 1 : 0;
    @(posedge clk); #1;
    if (!al) begin
      rd_model = '0;
      check("mis_pulse", 32'(misaligned), 32'd1);
      check("mis_no_cyc", 32'(bus_if.cyc), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_rdata", read_data, 32'd0);
    end else begin
      check("req_cyc", 32'(bus_if.cyc), 32'd1);
      check("req_stb", 32'(bus_if.stb), 32'd1);
      check("req_we", 32'(bus_if.we), 32'(we));
      check("req_adr", bus_if.adr, {a[31:2], 2'b00});
      check("req_sel", 32'(bus_if.sel), 32'(exp_sel));
      if (we) check("req_dat", bus_if.dat_o, exp_dat);
      for (int w = 0; w <= waits; w++) begin
        stall_cycles += stall ? 1 : 0;
        if (w == waits) begin
          bus_if.ack = (resp != 1);
          bus_if.err = (resp != 0);
          bus_if.dat_i = rdat;
        end else begin
          bus_if.ack = 1'b0;
          bus_if.err = 1'b0;
          bus_if.dat_i = $urandom;
        end
        @(posedge clk); #1;
        if (w < waits) check("wait_cyc", 32'(bus_if.cyc), 32'd1);
      end
      bus_if.ack = 1'b0;
      bus_if.err = 1'b0;
      if (resp != 0) rd_model = '0;
      else if (!we) rd_model = rdat >> (8 * (a % 4));
      check("done_cyc", 32'(bus_if.cyc), 32'd0);
      check("done_stb", 32'(bus_if.stb), 32'd0);
      check("done_fault", 32'(bus_fault), 32'(resp != 0));
      check("done_stall", 32'(stall), 32'd0);
      check("done_rdata", read_data, rd_model);
      check("stall_cycles", 32'(stall_cycles), 32'(waits + 2));
    end
    check("done_mis", 32'(misaligned), 32'(!al));
    mem_req = 1'b0;
    @(posedge clk); #1;
    check("idle_mis", 32'(misaligned), 32'd0);
    check("idle_fault", 32'(bus_fault), 32'd0);
    check("idle_rdata", read_data, rd_model);
  endtask

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(bus_if.cyc), 32'd0);
    check("rst_sel", 32'(bus_if.sel), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_fault", 32'(bus_fault), 32'd0);
    rst_n = 1'b1;

    // LW, zero-wait ack
    access(1'b0, F3_W, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    $display("LW 0x100 -> read_data %h", read_data);
    // SB to top lane
    access(1'b1, F3_B, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0);
    $display("SB 0x203 done");
    // LH misaligned
    access(1'b0, F3_H, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    $display("LH 0x101 misaligned");
    // LBU lane 2
    access(1'b0, F3_BU, 32'h0000_0102, 32'h0, 1, 0, 32'h1122_3344);
    $display("LBU 0x102 -> read_data %h", read_data);
    // SH upper half
    access(1'b1, F3_H, 32'h0000_0202, 32'h1234_BEEF, 2, 0, 32'h0);
    $display("SH 0x202 done");
    // ack and err together
    access(1'b0, F3_W, 32'h0000_0300, 32'h0, 0, 2, 32'hCAFE_F00D);
    $display("LW ack+err -> fault");

    // ack/err outside REQ are ignored
    access(1'b0, F3_W, 32'h0000_0400, 32'h0, 0, 0, 32'h5A5A_1234);
    bus_if.ack = 1'b1; bus_if.err = 1'b1; bus_if.dat_i = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("ign_cyc", 32'(bus_if.cyc), 32'd0);
    check("ign_fault", 32'(bus_fault), 32'd0);
    check("ign_rdata", read_data, rd_model);
    bus_if.ack = 1'b0; bus_if.err = 1'b0;
    $display("stray ack/err in IDLE ignored");

    // reset while in REQ
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; funct3 = F3_W; addr = 32'h0000_0500;
    @(posedge clk); #1;
    check("mid_cyc", 32'(bus_if.cyc), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rd_model = '0;
    check("midrst_cyc", 32'(bus_if.cyc), 32'd0);
    check("midrst_stb", 32'(bus_if.stb), 32'd0);
    check("midrst_fault", 32'(bus_fault), 32'd0);
    check("midrst_rdata", read_data, 32'd0);
    check("midrst_stall", 32'(stall), 32'd1);
    rst_n = 1'b1; mem_req = 1'b0;
    access(1'b0, F3_HU, 32'h0000_0502, 32'h0, 0, 0, 32'hA1B2_C3D4);
    $display("reset mid-REQ recovered");

`ifdef DMEM_TIMEOUT_EN
    begin
      int n;
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = 1'b0; funct3 = F3_W; addr = 32'h0000_0600;
      @(posedge clk); #1;
      n = 0;
      while (bus_fault !== 1'b1 && n < 20) begin
        n++;
        @(posedge clk); #1;
      end
      rd_model = '0;
      check("timeout_cycles", 32'(n), 32'd4);
      check("timeout_rdata", read_data, 32'd0);
      check("timeout_cyc", 32'(bus_if.cyc), 32'd0);
      mem_req = 1'b0;
      @(posedge clk); #1;
      $display("timeout after %0d REQ cycles", n);
    end
`else
    access(1'b0, F3_W, 32'h0000_0600, 32'h0, 120, 0, 32'h0BAD_F00D);
    $display("LW held 120 wait cycles -> read_data %h", read_data);
`endif

    for (int n = 0; n < 40; n++) begin
      logic        rwe;
      logic [2:0]  f;
      logic [31:0] a;
      int          r;
      int          rsp;
      int          wt;
      rwe = 1'($urandom_range(0, 1));
      f   = rwe ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a   = $urandom;
      r   = $urandom_range(0, 9);
      rsp = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      wt  = $urandom_range(0, 3);
      access(rwe, f, a, $urandom, wt, rsp, $urandom);
      $display("rand %0d: we=%0d f3=%0d addr=%h resp=%0d rdata=%h", n, rwe, f, a, rsp, read_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: REQ-state cycles without bus_ack/bus_err before abort; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous and active-low.
REQ-004 mem_req  in  1  core load/store request; held with operands stable while stall=1.
REQ-005 mem_we  in  1  1=store, 0=load.
REQ-006 funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  byte address from ALU output.
REQ-008 wdata  in  32  store data (rs2 value).
REQ-009 read_data  out  32  load data shifted to bit 0, not extended; registered.
REQ-010 stall  out  1  core must hold PC and suppress register write.
REQ-011 misaligned  out  1  one-cycle fault pulse, misaligned access.
REQ-012 bus_fault  out  1  one-cycle fault pulse, bus error or timeout.
REQ-013 bus_cyc, bus_stb  out  1 each  bus cycle/strobe; registered.
REQ-014 bus_we  out  1  bus write enable; registered.
REQ-015 bus_adr  out  32  word address, {addr[31:2],2'b00}; registered.
REQ-016 bus_sel  out  4  byte lane enables; registered.
REQ-017 bus_dat_o  out  32  store data, lane-replicated; registered.
REQ-018 bus_dat_i  in  32  bus read data, valid with bus_ack.
REQ-019 bus_ack, bus_err  in  1 each  bus completion / error.

Function
REQ-020 FSM states IDLE, REQ, DONE shall be used.
REQ-021 IDLE: mem_req=1 and aligned -> REQ with bus_cyc=bus_stb=1 and bus_we/adr/sel/dat_o loaded; misaligned -> DONE without a bus cycle.
REQ-022 Alignment: H/HU need addr[0]=0; W and reserved funct3 (011,110,111, treated as W) need addr[1:0]=00; B/BU always aligned.
REQ-023 bus_sel: store B 0001<<addr[1:0]; store H 0011<<{addr[1],1'b0}; store W and all loads 1111.
REQ-024 bus_dat_o: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-025 REQ: bus_err=1 -> DONE, bus_fault pulse, read_data=0; else bus_ack=1 -> DONE, read_data=bus_dat_i>>(8*addr[1:0]) for loads, unchanged for stores; bus_err wins when both high.
REQ-026 bus_cyc/bus_stb shall drop on the edge leaving REQ.
REQ-027 DONE: always -> IDLE next cycle; misaligned path sets read_data=0, misaligned pulse, no bus write.
REQ-028 stall = mem_req & (state!=DONE), combinational; zero-wait load/store therefore occupies 3 cycles.
REQ-029 bus_ack/bus_err outside REQ shall be ignored; mem_req=0 in IDLE leaves all outputs unchanged.
REQ-030 misaligned and bus_fault shall be high only during the DONE cycle of the faulting access.

Reset
REQ-031 rst_n=0 at a clock edge: state IDLE, all outputs and timeout counter 0, including mid-REQ (bus cycle abandoned, no fault pulse).

Configuration
REQ-032 Macro DMEM_TIMEOUT_EN defined: 8-bit counter clears on REQ entry, increments each REQ cycle; reaching TIMEOUT_CYCLES without ack/err -> DONE, bus_fault pulse, read_data=0.
REQ-033 DMEM_TIMEOUT_EN undefined: no counter, REQ waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-034 Package dmem_pkg: state enum, funct3 localparams (B,H,W,BU,HU), TIMEOUT_CYCLES default.
REQ-035 Sub-module dmem_lane_align: combinational alignment check, bus_sel, bus_dat_o replication, load shift.

Verification
REQ-036 LW addr 0x100, ack first REQ cycle, bus_dat_i 0xDEADBEEF -> read_data 0xDEADBEEF, stall high 2 cycles, bus_sel 1111.
REQ-037 SB addr 0x203, wdata 0x000000A5 -> bus_adr 0x200, bus_sel 1000, bus_dat_o 0xA5A5A5A5, bus_we 1.
REQ-038 LH addr 0x101 -> no bus_cyc, misaligned pulse in DONE, read_data 0; LBU addr 0x102, bus_dat_i 0x11223344 -> read_data 0x00001122.
REQ-039 bus_ack and bus_err high together in REQ -> bus_fault 1, read_data 0; rst_n low mid-REQ -> bus_cyc 0 next edge, state IDLE.
REQ-040 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES 4, no ack -> bus_fault after 4 REQ cycles; without macro -> stall held 100+ cycles, then ack completes.
